dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/dmem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Holds halt-FSM states, port ids and byte-enable width.
package dmem_port_arbiter_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_st_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: bit0 = CPU, bit1 = DBG.
// On contention the port not granted last time wins.
module rr_arb2
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT_CPU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU and the debug controller.
// Debug can freeze CPU traffic via a RUN/DRAIN/HALTED handshake.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic [BE_W-1:0]   cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [BE_W-1:0]   dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              halted,
  output logic              mem_cs,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  halt_st_t         r_state;
  halt_st_t         w_state_nx;
  port_id_t         r_last;
  logic             r_cpu_rd;
  logic             r_dbg_rd;
  logic [CNT_W-1:0] r_cnt;

  logic       w_cpu_ok;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_cpu_rd;
  logic       w_dbg_rd;
  logic       w_conflict;

  assign w_cpu_ok = (r_state == RUN) & ~RST;
  assign w_req    = {dbg_req & ~RST,
                     cpu_req & w_cpu_ok};

  rr_arb2 u_rr (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign cpu_gnt = w_gnt[0];
  assign dbg_gnt = w_gnt[1];
  assign mem_cs  = cpu_gnt | dbg_gnt;

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      dbg_gnt: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign w_cpu_rd = cpu_gnt & (cpu_we == '0);
  assign w_dbg_rd = dbg_gnt & (dbg_we == '0);

  // CPU stalled by the halt also counts as contention
  assign w_conflict = ~RST & cpu_req &
                      (dbg_req | (r_state != RUN));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      RUN: begin
        if (dbg_halt)
          w_state_nx = w_cpu_rd ? DRAIN : HALTED;
      end
      DRAIN:  w_state_nx = HALTED;
      HALTED: begin
        if (!dbg_halt)
          w_state_nx = RUN;
      end
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= RUN;
      r_last   <= PORT_DBG;
      r_cpu_rd <= 1'b0;
      r_dbg_rd <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cpu_rd <= w_cpu_rd;
      r_dbg_rd <= w_dbg_rd;
      if (cpu_gnt)
        r_last <= PORT_CPU;
      else if (dbg_gnt)
        r_last <= PORT_DBG;
      if (w_conflict && (r_cnt != '1))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cpu_rvalid   = r_cpu_rd & ~RST;
  assign dbg_rvalid   = r_dbg_rd & ~RST;
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata    = dbg_rvalid ? mem_rdata : '0;
  assign halted       = (r_state == HALTED) & ~RST;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, dbg_req, dbg_halt;
  logic [3:0]  cpu_we, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] mem_rdata;

  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        halted, mem_cs;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] conflict_cnt;

  logic        w4_cg, w4_crv, w4_dg, w4_drv, w4_halted, w4_cs;
  logic [31:0] w4_crd, w4_drd, w4_addr, w4_wd;
  logic [3:0]  w4_we;
  logic [3:0]  w4_cnt;

  always #5 CLK = ~CLK;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .halted(halted),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(w4_cg),
    .cpu_rvalid(w4_crv), .cpu_rdata(w4_crd),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(w4_dg),
    .dbg_rvalid(w4_drv), .dbg_rdata(w4_drd),
    .dbg_halt(dbg_halt), .halted(w4_halted),
    .mem_cs(w4_cs), .mem_we(w4_we), .mem_addr(w4_addr),
    .mem_wdata(w4_wd), .mem_rdata(mem_rdata),
    .conflict_cnt(w4_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: mode 0 = running, 1 = draining, 2 = halted
  int m_mode;
  bit m_last_cpu;
  bit m_cpu_pend, m_dbg_pend;
  int m_cnt, m_cnt4;
  bit e_cg, e_dg;

  task automatic m_reset();
    m_mode     = 0;
    m_last_cpu = 1'b0;
    m_cpu_pend = 1'b0;
    m_dbg_pend = 1'b0;
    m_cnt      = 0;
    m_cnt4     = 0;
  endtask

  task automatic eval();
    bit rst, cok, cg, dg, crv, drv;
    logic [3:0]  we;
    logic [31:0] ad, wd;
    @(negedge CLK);
    rst = RST;
    cok = !rst && (m_mode == 0);
    cg  = cpu_req && cok && !(dbg_req && m_last_cpu);
    dg  = dbg_req && !rst && !cg;
    we = 4'h0; ad = 32'h0; wd = 32'h0;
    if (cg) begin
      we = cpu_we; ad = cpu_addr; wd = cpu_wdata;
    end else if (dg) begin
      we = dbg_we; ad = dbg_addr; wd = dbg_wdata;
    end
    crv = !rst && m_cpu_pend;
    drv = !rst && m_dbg_pend;
    chk("m cpu_gnt", cpu_gnt, cg);
    chk("m dbg_gnt", dbg_gnt, dg);
    chk("m mem_cs", mem_cs, cg | dg);
    chk("m mem_we", mem_we, we);
    chk("m mem_addr", mem_addr, ad);
    chk("m mem_wdata", mem_wdata, wd);
    chk("m cpu_rvalid", cpu_rvalid, crv);
    chk("m cpu_rdata", cpu_rdata, crv ? mem_rdata : 32'h0);
    chk("m dbg_rvalid", dbg_rvalid, drv);
    chk("m dbg_rdata", dbg_rdata, drv ? mem_rdata : 32'h0);
    chk("m halted", halted, !rst && (m_mode == 2));
    chk("m conflict_cnt", conflict_cnt, m_cnt);
    chk("m conflict_cnt4", w4_cnt, m_cnt4);
    e_cg = cg;
    e_dg = dg;
  endtask

  task automatic adv();
    @(posedge CLK);
    if (RST) begin
      m_reset();
    end else begin
      if (cpu_req && (dbg_req || m_mode != 0)) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_cpu_pend = e_cg && (cpu_we == 4'h0);
      m_dbg_pend = e_dg && (dbg_we == 4'h0);
      if (e_cg) m_last_cpu = 1'b1;
      else if (e_dg) m_last_cpu = 1'b0;
      case (m_mode)
        0: if (dbg_halt)
             m_mode = (e_cg && cpu_we == 4'h0) ? 1 : 2;
        1: m_mode = 2;
        default: if (!dbg_halt) m_mode = 0;
      endcase
    end
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic setin(bit cr, logic [3:0] cw, logic [31:0] ca,
                       logic [31:0] cd, bit dr, logic [3:0] dw,
                       logic [31:0] da, logic [31:0] dd, bit h);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    dbg_halt = h;
  endtask

  typedef struct {
    bit          rst;
    bit          creq;
    logic [3:0]  cwe;
    logic [31:0] caddr;
    bit          dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    bit          xcg;
    bit          xdg;
    logic [31:0] xaddr;
    bit          xcrv;
    bit          xdrv;
    int          xcnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 1, 4'h0, 32'h10, 1, 4'h0, 32'h40, 0, 0, 32'h0,  0, 0, 0};
    tbl[1] = '{0, 1, 4'h0, 32'h10, 1, 4'h0, 32'h40, 1, 0, 32'h10, 0, 0, 0};
    tbl[2] = '{0, 1, 4'h0, 32'h10, 1, 4'h0, 32'h40, 0, 1, 32'h40, 1, 0, 1};
    tbl[3] = '{0, 1, 4'h0, 32'h10, 1, 4'h0, 32'h40, 1, 0, 32'h10, 0, 1, 2};
    tbl[4] = '{0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 32'h0,  1, 0, 3};
    tbl[5] = '{0, 1, 4'h0, 32'h10, 0, 4'h0, 32'h0,  1, 0, 32'h10, 0, 0, 3};
    tbl[6] = '{0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 32'h0,  1, 0, 3};
    tbl[7] = '{0, 0, 4'h0, 32'h0,  1, 4'hF, 32'h44, 0, 1, 32'h44, 0, 0, 3};
    tbl[8] = '{0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 0, 3};

    mem_rdata = 32'h0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    m_reset();

    for (int i = 0; i < 9; i++) begin
      RST = tbl[i].rst;
      setin(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, 32'h1111_0000,
            tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, 32'h2222_0000, 0);
      eval();
      chk($sformatf("tbl%0d cpu_gnt", i), cpu_gnt, tbl[i].xcg);
      chk($sformatf("tbl%0d dbg_gnt", i), dbg_gnt, tbl[i].xdg);
      chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].xaddr);
      chk($sformatf("tbl%0d cpu_rvalid", i), cpu_rvalid, tbl[i].xcrv);
      chk($sformatf("tbl%0d dbg_rvalid", i), dbg_rvalid, tbl[i].xdrv);
      chk($sformatf("tbl%0d conflict_cnt", i), conflict_cnt,
          tbl[i].xcnt);
      adv();
    end

    // halt with CPU read in flight, then debug owns memory
    RST = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval(); adv();
    RST = 1'b0;
    setin(1, 0, 32'h30, 0, 0, 0, 0, 0, 1);
    eval();
    chk("drain grant", cpu_gnt, 1);
    chk("drain addr", mem_addr, 32'h30);
    chk("drain halted0", halted, 0);
    adv();
    setin(1, 0, 32'h34, 0, 0, 0, 0, 0, 1);
    eval();
    chk("drain no gnt", cpu_gnt, 0);
    chk("drain rvalid", cpu_rvalid, 1);
    chk("drain halted1", halted, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      setin(1, 0, 32'h34, 0, i == 0, 4'hF, 32'h20,
            32'hDEAD_BEEF, 1);
      eval();
      chk("halt cpu blocked", cpu_gnt, 0);
      chk("halt halted", halted, 1);
      if (i == 0) begin
        chk("halt dbg gnt", dbg_gnt, 1);
        chk("halt dbg we", mem_we, 4'hF);
        chk("halt dbg addr", mem_addr, 32'h20);
        chk("halt dbg wdata", mem_wdata, 32'hDEAD_BEEF);
      end else begin
        chk("halt no dbg rvalid", dbg_rvalid, 0);
      end
      adv();
    end
    setin(1, 0, 32'h34, 0, 0, 0, 0, 0, 0);
    eval();
    chk("resume still halted", halted, 1);
    chk("resume no gnt yet", cpu_gnt, 0);
    adv();
    eval();
    chk("resume run", halted, 0);
    chk("resume cpu gnt", cpu_gnt, 1);
    chk("resume addr", mem_addr, 32'h34);
    adv();

    // halt dropped while draining still visits HALTED
    setin(1, 0, 32'h50, 0, 0, 0, 0, 0, 1);
    eval();
    chk("d2 gnt", cpu_gnt, 1);
    adv();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("d2 draining", halted, 0);
    adv();
    eval();
    chk("d2 halted pass", halted, 1);
    adv();
    eval();
    chk("d2 back to run", halted, 0);
    adv();

    // reset right after a debug read grant drops its rvalid
    setin(0, 0, 0, 0, 1, 0, 32'h60, 0, 0);
    eval();
    chk("rst dbg gnt", dbg_gnt, 1);
    adv();
    RST = 1'b1;
    setin(1, 4'h3, 32'h70, 32'h5, 1, 4'h0, 32'h74, 32'h6, 1);
    eval();
    chk("rst dbg_rvalid", dbg_rvalid, 0);
    chk("rst dbg_rdata", dbg_rdata, 0);
    chk("rst gnts", {cpu_gnt, dbg_gnt}, 0);
    chk("rst mem_cs", mem_cs, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst halted", halted, 0);
    adv();
    RST = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("post rst dbg_rvalid", dbg_rvalid, 0);
    chk("post rst cnt", conflict_cnt, 0);
    adv();

    // counter saturation on the 4-bit build
    for (int i = 0; i < 20; i++) begin
      setin(1, 0, 32'h80, 0, 1, 0, 32'h84, 0, 0);
      eval(); adv();
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("sat cnt4", w4_cnt, 4'hF);
    chk("sat cnt16", conflict_cnt, 20);
    adv();

    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 49) == 0);
      setin($urandom_range(0, 1),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
            $urandom, $urandom,
            $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
            $urandom, $urandom,
            ($urandom_range(0, 9) == 0) ? !dbg_halt : dbg_halt);
      eval(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
